lcd_char_writer: RTL and testbench

- Drives a 16x2 HD44780-compatible character LCD in 8-bit, write-only mode.
- Runs the power-up initialisation, then refreshes the screen continuously:
  - it presents a 5-bit character index (0..31) to the display-list block;
  - it captures the returned ASCII byte one clock later;
  - it writes line 1 (indices 0..15) and line 2 (indices 16..31) to the panel with correctly timed RS/E strobes.
- It consumes the character stream from the display-list block and drives the physical LCD pins.

---
 rtl/lcd_char_writer.sv | 116 +++++++++++
 tb/tb_lcd_char_writer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lcd_char_writer.sv
// lcd_char_writer: HD44780 16x2 8-bit write-only driver; runs power-up init, then refreshes both lines
// from a registered display-list source addressed by index.
module lcd_char_writer #(
    parameter int T_PWRUP = 750000,
    parameter int T_SU    = 4,
    parameter int T_PW    = 12,
    parameter int T_H     = 4,
    parameter int T_WAIT  = 2500,
    parameter int T_CLR   = 100000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);
    typedef enum logic [2:0] {PWRUP, INIT_CMD, WR_SETUP, WR_PULSE, WR_HOLD, WR_WAIT, FETCH} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lim;
    logic [1:0]       step;
    logic             clr;
    logic             done;

    function automatic logic [7:0] cmd_of(input logic [1:0] s);
        return s == 2'd0 ? 8'h38 : s == 2'd1 ? 8'h0C : s == 2'd2 ? 8'h06 : 8'h01;
    endfunction

    assign lcd_rw = 1'b0;

    always_comb begin
        clr  = !lcd_rs && lcd_data == 8'h01;
        lim  = state == PWRUP    ? CNT_W'(T_PWRUP - 1) :
               state == WR_SETUP ? CNT_W'(T_SU - 1) :
               state == WR_PULSE ? CNT_W'(T_PW - 1) :
               state == WR_HOLD  ? CNT_W'(T_H - 1) :
               state == WR_WAIT  ? (clr ? CNT_W'(T_CLR - 1) : CNT_W'(T_WAIT - 1)) :
               state == FETCH    ? CNT_W'(1) : '0;
        done = cnt == lim;
    end

    // Line commands are loaded straight from the expiring wait so they cost no extra cycle;
    // after a line command, lcd_data[6] tells which line's first index to fetch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= PWRUP;
            cnt        <= '0;
            step       <= '0;
            index      <= '0;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cnt        <= done ? '0 : cnt + 1'b1;
            frame_done <= 1'b0;
            if (done) begin
                case (state)
                    PWRUP: state <= INIT_CMD;
                    INIT_CMD: begin
                        state    <= WR_SETUP;
                        lcd_rs   <= 1'b0;
                        lcd_data <= cmd_of(step);
                    end
                    WR_SETUP: begin
                        state <= WR_PULSE;
                        lcd_e <= 1'b1;
                    end
                    WR_PULSE: begin
                        state <= WR_HOLD;
                        lcd_e <= 1'b0;
                    end
                    WR_HOLD: state <= WR_WAIT;
                    WR_WAIT: begin
                        if (!init_done) begin
                            state  <= WR_SETUP;
                            lcd_rs <= 1'b0;
                            if (step == 2'd3) begin
                                init_done <= 1'b1;
                                lcd_data  <= 8'h80;
                            end else begin
                                step     <= step + 2'd1;
                                lcd_data <= cmd_of(step + 2'd1);
                            end
                        end else if (!lcd_rs) begin
                            state <= FETCH;
                            index <= lcd_data[6] ? 5'd16 : 5'd0;
                        end else if (index[3:0] == 4'hF) begin
                            state      <= WR_SETUP;
                            lcd_rs     <= 1'b0;
                            lcd_data   <= index[4] ? 8'h80 : 8'hC0;
                            frame_done <= index[4];
                        end else begin
                            state <= FETCH;
                            index <= index + 5'd1;
                        end
                    end
                    FETCH: begin
                        state    <= WR_SETUP;
                        lcd_rs   <= 1'b1;
                        lcd_data <= char_in;
                    end
                    default: state <= PWRUP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb_lcd_char_writer: directed bench with a registered ROM model returning 8'h41 + index.
module tb_lcd_char_writer;
    localparam int T_H = 2;

    logic       clk;
    logic       rst;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int mv    = 0;
    int fd_count = 0;
    int id_rises = 0;
    int n;
    int hi;

    lcd_char_writer #(
        .T_PWRUP(20), .T_SU(2), .T_PW(3), .T_H(T_H), .T_WAIT(5), .T_CLR(10), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .char_in(char_in), .index(index), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data), .init_done(init_done),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) char_in <= 8'h41 + index;

    logic       rst_q = 1'b0;
    logic       e_prev = 1'b0;
    logic       fd_prev = 1'b0;
    logic       id_prev = 1'b0;
    logic [8:0] bus_prev = '0;
    int         since = 100;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q && (lcd_e === 1'b1 || e_prev || since <= T_H) && {lcd_rs, lcd_data} !== bus_prev) begin
            mv++;
            $error("FAIL bus_stable obs=%h exp=%h", {lcd_rs, lcd_data}, bus_prev);
        end
        if (lcd_rw !== 1'b0) begin
            mv++;
            $error("FAIL lcd_rw obs=%b exp=0", lcd_rw);
        end
        if (frame_done === 1'b1) begin
            if (fd_prev) begin
                mv++;
                $error("FAIL frame_done_width obs=wide exp=1cycle");
            end else fd_count++;
            if (init_done !== 1'b1) begin
                mv++;
                $error("FAIL frame_before_init obs=%b exp=1", init_done);
            end
        end
        if (init_done === 1'b1 && !id_prev) id_rises++;
        since    = (lcd_e === 1'b1) ? 0 : since + 1;
        e_prev   = (lcd_e === 1'b1);
        fd_prev  = (frame_done === 1'b1);
        id_prev  = (init_done === 1'b1);
        bus_prev = {lcd_rs, lcd_data};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic to_rise(output int c);
        c = 0;
        while (lcd_e !== 1'b1 && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic to_fall(output int c);
        c = 0;
        while (lcd_e !== 1'b0 && c < 2000) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    task automatic next_write();
        int c;
        to_fall(c);
        to_rise(c);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_index", 32'(index), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_e", 32'(lcd_e), 0);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        rst = 1'b1;
        to_rise(n);
        chk("pwrup_rise", n, 23);
        hi = 0;
        while (lcd_e === 1'b1 && hi < 50) begin
            chk("cmd38", 32'({lcd_rs, lcd_data}), 32'h038);
            hi++;
            @(posedge clk); #1;
        end
        chk("e_width", hi, 3);
        to_rise(n);
        chk("cmd0c", 32'({lcd_rs, lcd_data}), 32'h00C);
        next_write();
        chk("cmd06", 32'({lcd_rs, lcd_data}), 32'h006);
        next_write();
        chk("cmd01", 32'({lcd_rs, lcd_data}), 32'h001);
        chk("init_pending", 32'(init_done), 0);
        to_fall(n);
        to_rise(n);
        chk("clr_gap", n, 14);
        chk("cmd80", 32'({lcd_rs, lcd_data}), 32'h080);
        chk("init_done", 32'(init_done), 1);
        for (int f = 0; f < 3; f++) begin
            if (f > 0) begin
                next_write();
                chk("line1", 32'({lcd_rs, lcd_data}), 32'h080);
            end
            for (int k = 0; k < 32; k++) begin
                if (k == 16) begin
                    next_write();
                    chk("line2", 32'({lcd_rs, lcd_data}), 32'h0C0);
                end
                next_write();
                chk("char", 32'({lcd_rs, lcd_data}), 32'h141 + k);
                chk("char_index", 32'(index), k);
            end
        end
        next_write();
        chk("frame4_cmd", 32'({lcd_rs, lcd_data}), 32'h080);
        chk("index_hold", 32'(index), 31);
        chk("frame_count", fd_count, 3);
        chk("init_once", id_rises, 1);
        next_write();
        chk("wrap_index", 32'(index), 0);
        chk("wrap_char", 32'({lcd_rs, lcd_data}), 32'h141);
        chk("mid_write_e", 32'(lcd_e), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_e", 32'(lcd_e), 0);
        chk("rst_mid_index", 32'(index), 0);
        chk("rst_mid_init", 32'(init_done), 0);
        rst = 1'b1;
        to_rise(n);
        chk("repwrup_rise", n, 23);
        chk("recmd38", 32'({lcd_rs, lcd_data}), 32'h038);
        chk("monitor", mv, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
